switch_debounce: RTL and testbench
==================================

// Module: switch_debounce
// PURPOSE
//   Debounces raw push-button inputs before they reach LED/toggle logic.
//   Synchronises each switch into i_clk, filters bounce with a per-channel
//   stability counter, and emits a clean level plus one-cycle press/release
//   pulses. Sits between the board switch pins and the LED toggle stage.
// PARAMETERS
//   NUM_SWITCHES    4       number of independent switch channels (>=1)
//   DEBOUNCE_LIMIT  250000  consecutive stable cycles required to accept a change (>=1; 10 ms @ 25 MHz)
//   SYNC_STAGES     2       synchroniser flop depth per channel (>=2)
// PORTS
//   i_clk        in   1             system clock, all logic on rising edge
//   i_rst_n      in   1             asynchronous active-low reset
//   i_switch     in   NUM_SWITCHES  raw switch pins, asynchronous, 1 = pressed
//   o_switch     out  NUM_SWITCHES  debounced level per channel
//   o_press      out  NUM_SWITCHES  1-cycle pulse on debounced 0->1
//   o_release    out  NUM_SWITCHES  1-cycle pulse on debounced 1->0
//   o_glitch_cnt out  8             aborted-debounce count (only with SWITCH_DEBOUNCE_GLITCH_CNT_EN)
// BEHAVIOUR
//   - Reset (i_rst_n=0, async assert, sync release): sync flops, counters,
//     o_switch, o_press, o_release, o_glitch_cnt all 0.
//   - Sync: SYNC_STAGES flop chain per channel; s = last stage output.
//   - Per channel, each edge:
//       s == o_switch: counter <= 0.
//       s != o_switch, counter <  DEBOUNCE_LIMIT-1: counter <= counter+1.
//       s != o_switch, counter == DEBOUNCE_LIMIT-1: o_switch <= s, counter <= 0,
//         o_press/o_release <= 1 for this cycle per direction.
//   - o_press/o_release registered, high exactly one cycle, same cycle
//     o_switch changes; never both high on one channel.
//   - Latency: i_switch stable from edge 0 -> o_switch updates at edge
//     SYNC_STAGES+DEBOUNCE_LIMIT; DEBOUNCE_LIMIT=1 gives SYNC_STAGES+1.
//   - Counter width $clog2(DEBOUNCE_LIMIT+1); never exceeds DEBOUNCE_LIMIT-1, no wrap.
//   - Bounce: any return of s to o_switch before limit clears counter; no
//     output change, no pulse. Next mismatch restarts count from 0.
//   - Channels fully independent; simultaneous changes on several channels
//     produce simultaneous pulses.
//   - Reset mid-count discards progress; full latency applies after release.
// CONFIGURATION
//   SWITCH_DEBOUNCE_GLITCH_CNT_EN defined:
//     o_glitch_cnt present. Increments by 1 on any cycle where >=1 channel
//     has counter != 0 and s == o_switch (abort); multiple aborts in one
//     cycle count once. Saturates at 255, no wrap. Cleared only by reset.
//   Not defined: o_glitch_cnt port and its logic absent; all else identical.
// TESTING (DEBOUNCE_LIMIT=4, SYNC_STAGES=2, NUM_SWITCHES=4)
//   1 i_rst_n=0, toggle i_switch=4'hF/4'h0 -> o_switch/o_press/o_release stay 4'h0.
//   2 i_switch[0] 0->1 held -> o_switch[0]=1 at edge 6, o_press=4'h1 for that
//     single cycle, o_release=4'h0 throughout.
//   3 i_switch[1] high 3 cycles then low -> o_switch[1]=0, no pulses; with
//     macro o_glitch_cnt=1; 300 such bounces -> o_glitch_cnt=255.
//   4 from debounced 1, i_switch[0] 1->0 held -> o_release=4'h1 one cycle at
//     edge 6, o_switch[0]=0.
//   5 i_switch 4'h0->4'hF same edge -> o_press=4'hF one cycle at edge 6, o_switch=4'hF.
//   6 i_switch[2] 0->1, i_rst_n pulsed low at edge 4 -> outputs 0; after
//     release o_switch[2]=1 exactly 6 edges later with pulse.

Source files
------------

// File: rtl/switch_debounce.sv
// Multi-channel push-button debouncer: per-channel synchroniser, stability counter,
// clean level plus press/release pulses. Optional abort counter via SWITCH_DEBOUNCE_GLITCH_CNT_EN.
module switch_debounce #(
    parameter int NUM_SWITCHES   = 4,
    parameter int DEBOUNCE_LIMIT = 250000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [NUM_SWITCHES-1:0] i_switch,
    output logic [NUM_SWITCHES-1:0] o_switch,
    output logic [NUM_SWITCHES-1:0] o_press,
    output logic [NUM_SWITCHES-1:0] o_release
`ifdef SWITCH_DEBOUNCE_GLITCH_CNT_EN
    ,
    output logic [7:0]              o_glitch_cnt
`endif
);

    localparam int            CW      = $clog2(DEBOUNCE_LIMIT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_LIMIT - 1);

`ifdef SWITCH_DEBOUNCE_GLITCH_CNT_EN
    logic [NUM_SWITCHES-1:0] abort;
`endif

    for (genvar i = 0; i < NUM_SWITCHES; i++) begin : g_lane
        logic [SYNC_STAGES-1:0] sync_q;
        logic [CW-1:0]          cnt_q;
        logic                   sw_q, pr_q, rl_q;
        logic                   s;

        assign s            = sync_q[SYNC_STAGES-1];
        assign o_switch[i]  = sw_q;
        assign o_press[i]   = pr_q;
        assign o_release[i] = rl_q;
`ifdef SWITCH_DEBOUNCE_GLITCH_CNT_EN
        // Counting had started but the input fell back before acceptance.
        assign abort[i] = (cnt_q != '0) && (s == sw_q);
`endif

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                sync_q <= '0;
                cnt_q  <= '0;
                sw_q   <= 1'b0;
                pr_q   <= 1'b0;
                rl_q   <= 1'b0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], i_switch[i]};
                pr_q   <= 1'b0;
                rl_q   <= 1'b0;
                if (s == sw_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == CNT_MAX) begin
                    sw_q  <= s;
                    cnt_q <= '0;
                    pr_q  <= s;
                    rl_q  <= ~s;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

`ifdef SWITCH_DEBOUNCE_GLITCH_CNT_EN
    // Simultaneous aborts on several channels count as a single event.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            o_glitch_cnt <= '0;
        else if ((|abort) && (o_glitch_cnt != 8'hFF))
            o_glitch_cnt <= o_glitch_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce: expected outputs are queued with the cycle
// they are due and compared at the falling edge of that cycle.
module tb_switch_debounce;
    localparam int NSW = 4;

    logic           i_clk;
    logic           i_rst_n;
    logic [NSW-1:0] i_switch;
    logic [NSW-1:0] o_switch, o_press, o_release;
`ifdef SWITCH_DEBOUNCE_GLITCH_CNT_EN
    logic [7:0]     o_glitch_cnt;
`endif

    switch_debounce #(
        .NUM_SWITCHES  (NSW),
        .DEBOUNCE_LIMIT(4),
        .SYNC_STAGES   (2)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_switch    (i_switch),
        .o_switch    (o_switch),
        .o_press     (o_press),
        .o_release   (o_release)
`ifdef SWITCH_DEBOUNCE_GLITCH_CNT_EN
        ,
        .o_glitch_cnt(o_glitch_cnt)
`endif
    );

    typedef struct {
        int             cyc;
        logic [NSW-1:0] sw;
        logic [NSW-1:0] pr;
        logic [NSW-1:0] rl;
        logic [7:0]     g;
        string          tag;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input string fld, input logic [7:0] obs, input logic [7:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s.%s: observed %h expected %h (cycle %0d)", tag, fld, obs, exp_v, cyc);
        end
    endtask

    always @(negedge i_clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            chk(e.tag, "o_switch",  8'(o_switch),  8'(e.sw));
            chk(e.tag, "o_press",   8'(o_press),   8'(e.pr));
            chk(e.tag, "o_release", 8'(o_release), 8'(e.rl));
`ifdef SWITCH_DEBOUNCE_GLITCH_CNT_EN
            chk(e.tag, "o_glitch_cnt", o_glitch_cnt, e.g);
`endif
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic expect_at(input int d, input string tag, input logic [NSW-1:0] sw,
                             input logic [NSW-1:0] pr, input logic [NSW-1:0] rl, input logic [7:0] g);
        exp_t x;
        x.cyc = cyc + d; x.sw = sw; x.pr = pr; x.rl = rl; x.g = g; x.tag = tag;
        sb.push_back(x);
    endtask

    initial begin
        i_rst_n  = 1'b0;
        i_switch = '0;

        // Reset held: switch activity must not reach the outputs.
        for (int i = 0; i < 6; i++) begin
            tick(1);
            i_switch = (i % 2 == 0) ? 4'hF : 4'h0;
            expect_at(0, "reset", 4'h0, 4'h0, 4'h0, 8'd0);
        end
        tick(1);
        i_switch = 4'h0;
        i_rst_n  = 1'b1;
        tick(4);

        // Press on channel 0 accepted at edge 6 with a single press pulse.
        i_switch = 4'h1;
        expect_at(5, "press0_pre",  4'h0, 4'h0, 4'h0, 8'd0);
        expect_at(6, "press0",      4'h1, 4'h1, 4'h0, 8'd0);
        expect_at(7, "press0_post", 4'h1, 4'h0, 4'h0, 8'd0);
        tick(8);

        // Channel 1 high for 3 cycles only: one short of acceptance, aborted.
        i_switch = 4'h3;
        for (int k = 1; k <= 10; k++)
            expect_at(k, "bounce1", 4'h1, 4'h0, 4'h0, (k >= 6) ? 8'd1 : 8'd0);
        tick(3);
        i_switch = 4'h1;
        tick(7);
        for (int b = 0; b < 299; b++) begin
            i_switch = 4'h3;
            tick(3);
            i_switch = 4'h1;
            tick(3);
        end
        tick(6);
        expect_at(0, "bounce300", 4'h1, 4'h0, 4'h0, 8'd255);
        tick(1);

        // Release of channel 0 from a debounced 1.
        i_switch = 4'h0;
        expect_at(5, "rel0_pre",  4'h1, 4'h0, 4'h0, 8'd255);
        expect_at(6, "rel0",      4'h0, 4'h0, 4'h1, 8'd255);
        expect_at(7, "rel0_post", 4'h0, 4'h0, 4'h0, 8'd255);
        tick(8);

        // All channels together, press then release.
        i_switch = 4'hF;
        expect_at(5, "pressF_pre",  4'h0, 4'h0, 4'h0, 8'd255);
        expect_at(6, "pressF",      4'hF, 4'hF, 4'h0, 8'd255);
        expect_at(7, "pressF_post", 4'hF, 4'h0, 4'h0, 8'd255);
        tick(8);
        i_switch = 4'h0;
        expect_at(6, "relF",      4'h0, 4'h0, 4'hF, 8'd255);
        expect_at(7, "relF_post", 4'h0, 4'h0, 4'h0, 8'd255);
        tick(8);

        // Reset mid-count on channel 2 discards progress.
        i_switch = 4'h4;
        expect_at(3, "rst_mid_pre", 4'h0, 4'h0, 4'h0, 8'd255);
        tick(4);
        i_rst_n = 1'b0;
        expect_at(0, "rst_mid", 4'h0, 4'h0, 4'h0, 8'd0);
        tick(1);
        expect_at(0, "rst_mid_hold", 4'h0, 4'h0, 4'h0, 8'd0);
        i_rst_n = 1'b1;
        expect_at(5, "post_rst_pre",  4'h0, 4'h0, 4'h0, 8'd0);
        expect_at(6, "post_rst",      4'h4, 4'h4, 4'h0, 8'd0);
        expect_at(7, "post_rst_post", 4'h4, 4'h0, 4'h0, 8'd0);
        tick(10);

        n_checks++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain: observed %0d pending expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
